// File: rtl/game_flow_ctrl.sv
// Game sequencer for the helicopter game: debounces the start button, sequences
// start/clear/halt of the pipe processor, keeps the BCD flight score and crash display timing.
module game_flow_ctrl #(
  parameter int TICK_DIV    = 2_500_000,
  parameter int DEB_CYCLES  = 500_000,
  parameter int BLINK_TICKS = 5,
  parameter int CRASH_TICKS = 40
) (
  input  logic        clock,
  input  logic        aclr,
  input  logic        start_n,
  input  logic        collision,
  output logic        proc_run,
  output logic        proc_clr,
  output logic [1:0]  disp_mode,
  output logic [15:0] score_bcd,
  output logic [2:0]  state_out
);

  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int BW = $clog2(BLINK_TICKS + 1);
  localparam int CW = $clog2(CRASH_TICKS + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_PLAY  = 3'd2,
    S_CRASH = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t          state, state_next;
  logic [1:0]      sync_q;
  logic            deb_level;
  logic [DW-1:0]   deb_cnt;
  logic            press_evt;
  logic [TW-1:0]   tick_cnt;
  logic            tick;
  logic [CW-1:0]   crash_cnt;
  logic [BW-1:0]   blink_cnt;
  logic            blink_phase;
  logic [15:0]     score_inc;

  // Sync chain and accepted level reset to "released" so no press is seen out of reset.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      sync_q    <= 2'b11;
      deb_level <= 1'b1;
      deb_cnt   <= '0;
    end else begin
      sync_q <= {sync_q[0], start_n};
      if (sync_q[1] != deb_level) begin
        if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
          deb_level <= sync_q[1];
          deb_cnt   <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  assign press_evt = deb_level && !sync_q[1] && (deb_cnt == DW'(DEB_CYCLES - 1));

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else tick_cnt <= tick_cnt + 1'b1;
  end

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  // BCD +1 with ripple carry across the four digits.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    logic carry;
    score_inc = score_bcd;
    carry     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (score_bcd[4*i +: 4] == 4'd9) begin
          score_inc[4*i +: 4] = 4'd0;
        end else begin
          score_inc[4*i +: 4] = score_bcd[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      score_bcd   <= '0;
      crash_cnt   <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      if (state == S_ARM) begin
        score_bcd <= '0;
      end else if (state == S_PLAY && tick && !collision && score_bcd != 16'h9999) begin
        score_bcd <= score_inc;
      end

      // Crash timers only live inside CRASH; they are re-zeroed everywhere else.
      if (state == S_CRASH) begin
        if (tick) begin
          crash_cnt <= crash_cnt + 1'b1;
          if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
          end else begin
            blink_cnt <= blink_cnt + 1'b1;
          end
        end
      end else begin
        crash_cnt   <= '0;
        blink_cnt   <= '0;
        blink_phase <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) state <= S_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = S_IDLE;
    proc_run   = 1'b0;
    proc_clr   = 1'b0;
    disp_mode  = 2'b00;
    case (state)
      S_IDLE: begin
        state_next = press_evt ? S_ARM : S_IDLE;
      end
      S_ARM: begin
        proc_clr   = 1'b1;
        state_next = S_PLAY;
      end
      S_PLAY: begin
        proc_run   = 1'b1;
        disp_mode  = 2'b01;
        state_next = collision ? S_CRASH : S_PLAY;
      end
      S_CRASH: begin
        disp_mode  = {1'b1, blink_phase};
        state_next = (tick && crash_cnt == CW'(CRASH_TICKS - 1)) ? S_HOLD : S_CRASH;
      end
      S_HOLD: begin
        disp_mode  = 2'b10;
        state_next = press_evt ? S_ARM : S_HOLD;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign state_out = state;

endmodule
